unrot_pipe: RTL and testbench

//  Pipelined inverse barrel rotator. out = bits rotated LEFT by k, undoing the

---
 rtl/rot_pkg.sv | 15 +
 rtl/unrot_stage.sv | 103 ++++++++++
 rtl/unrot_pipe.sv | 79 +++++++
 tb/tb_unrot_pipe.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// Shared constants and helpers for the rotator family (rot / unrot_pipe).
package rot_pkg;

  localparam int N_DEF      = 32;
  localparam int LOG2_N_DEF = 5;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Rotate distance contributed by stage s when its k bit is set.
  function automatic int stage_shift(input int n, input int s);
    return n >> (s + 1);
  endfunction

endpackage

// File: rtl/unrot_stage.sv
// One registered step of the inverse rotator: conditional rotate by N>>(S+1).
// Optional per-word direction when UNROT_DIR_EN is defined.
module unrot_stage
  import rot_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int LOG2_N = LOG2_N_DEF,
  parameter int S      = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
`ifdef UNROT_DIR_EN
  input  logic              in_dir,
  output logic              out_dir,
`endif
  input  logic              in_valid,
  input  logic [0:N-1]      in_bits,
  input  logic [0:LOG2_N-1] in_k,
  output logic              out_valid,
  output logic [0:N-1]      out_bits,
  output logic [0:LOG2_N-1] out_k
);

  localparam int SH = stage_shift(N, S);

  logic [0:N-1]      rot_left;
  logic [0:N-1]      step;
  logic              valid_q, valid_d;
  logic [0:N-1]      bits_q, bits_d;
  logic [0:LOG2_N-1] k_q, k_d;
`ifdef UNROT_DIR_EN
  logic [0:N-1]      rot_right;
  logic              dir_q, dir_d;
`endif

  // Index 0 is the MSB, so out[i] = in[(i + sh) % N] is a left rotate.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bit
      assign rot_left[gi] = in_bits[(gi + SH) % N];
`ifdef UNROT_DIR_EN
      assign rot_right[gi] = in_bits[(gi + N - SH) % N];
`endif
    end
  endgenerate

  always_comb begin
    step = in_bits;
    if (in_k[S]) begin
`ifdef UNROT_DIR_EN
      step = (in_dir == DIR_RIGHT) ? rot_right : rot_left;
`else
      step = rot_left;
`endif
    end
  end

  always_comb begin
    valid_d = valid_q;
    bits_d  = bits_q;
    k_d     = k_q;
`ifdef UNROT_DIR_EN
    dir_d   = dir_q;
`endif
    if (load) begin
      valid_d = in_valid;
      if (in_valid) begin
        bits_d = step;
        k_d    = in_k;
`ifdef UNROT_DIR_EN
        dir_d  = in_dir;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      bits_q  <= '0;
      k_q     <= '0;
`ifdef UNROT_DIR_EN
      dir_q   <= DIR_LEFT;
`endif
    end else begin
      valid_q <= valid_d;
      bits_q  <= bits_d;
      k_q     <= k_d;
`ifdef UNROT_DIR_EN
      dir_q   <= dir_d;
`endif
    end
  end

  assign out_valid = valid_q;
  assign out_bits  = bits_q;
  assign out_k     = k_q;
`ifdef UNROT_DIR_EN
  assign out_dir   = dir_q;
`endif

endmodule

// File: rtl/unrot_pipe.sv
// Pipelined inverse barrel rotator (left rotate by k), one stage per k bit.
// Define UNROT_DIR_EN to add a per-word dir input (1 = rotate right).
module unrot_pipe
  import rot_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int LOG2_N = LOG2_N_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:N-1]      bits,
  input  logic [0:LOG2_N-1] k,
`ifdef UNROT_DIR_EN
  input  logic              dir,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:N-1]      rotated_bits
);

  logic [0:N-1]      st_bits [0:LOG2_N];
  logic [0:LOG2_N-1] st_k    [0:LOG2_N];
  logic [LOG2_N:0]   st_valid;
  logic [LOG2_N-1:0] adv;
  logic              unused_tail;
`ifdef UNROT_DIR_EN
  logic [LOG2_N:0]   st_dir;

  assign st_dir[0]   = dir;
  assign unused_tail = ^{st_k[LOG2_N], st_dir[LOG2_N]};
`else
  assign unused_tail = ^st_k[LOG2_N];
`endif

  assign st_bits[0]  = bits;
  assign st_k[0]     = k;
  assign st_valid[0] = in_valid;

  genvar gi;
  generate
    for (gi = 0; gi < LOG2_N; gi++) begin : g_stage
      unrot_stage #(
        .N      (N),
        .LOG2_N (LOG2_N),
        .S      (gi)
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .load      (adv[gi]),
`ifdef UNROT_DIR_EN
        .in_dir    (st_dir[gi]),
        .out_dir   (st_dir[gi+1]),
`endif
        .in_valid  (st_valid[gi]),
        .in_bits   (st_bits[gi]),
        .in_k      (st_k[gi]),
        .out_valid (st_valid[gi+1]),
        .out_bits  (st_bits[gi+1]),
        .out_k     (st_k[gi+1])
      );
    end
  endgenerate

  // A stage may load when it is empty or its contents move on this cycle.
  always_comb begin
    adv = '0;
    adv[LOG2_N-1] = !st_valid[LOG2_N] || out_ready;
    for (int s = LOG2_N - 2; s >= 0; s--) begin
      adv[s] = !st_valid[s+1] || adv[s+1];
    end
  end

  assign in_ready     = adv[0];
  assign out_valid    = st_valid[LOG2_N];
  assign rotated_bits = st_bits[LOG2_N];

endmodule

// File: tb/tb_unrot_pipe.sv
// Directed bench for unrot_pipe at N=8 and N=32; honours UNROT_DIR_EN.
module tb_unrot_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       iv8, ir8, ov8, or8, d8;
  logic [7:0] b8, rb8;
  logic [2:0] k8;

  logic        iv32, ir32, ov32, or32, d32;
  logic [31:0] b32, rb32;
  logic [4:0]  k32;

  unrot_pipe #(.N(8), .LOG2_N(3)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .bits(b8), .k(k8),
`ifdef UNROT_DIR_EN
    .dir(d8),
`endif
    .out_valid(ov8), .out_ready(or8), .rotated_bits(rb8)
  );

  unrot_pipe #(.N(32), .LOG2_N(5)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .bits(b32), .k(k32),
`ifdef UNROT_DIR_EN
    .dir(d32),
`endif
    .out_valid(ov32), .out_ready(or32), .rotated_bits(rb32)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_acc8 = 0, n_emit8 = 0, acc8_cyc = 0, emit8_cyc = 0;
  int n_acc32 = 0, n_emit32 = 0, first_acc32 = 0, first_emit32 = 0, last_emit32 = 0;
  logic [7:0]  lo8;
  logic [31:0] fo32;
  logic [7:0]  q8[$];
  logic [31:0] q32[$];

  function automatic logic [7:0] ref8(input logic [7:0] b, input logic [2:0] k, input logic d);
    logic [15:0] x;
    x = {b, b};
    if (d) begin
      x = x >> k;
      return x[7:0];
    end
    x = x << k;
    return x[15:8];
  endfunction

  function automatic logic [31:0] ref32(input logic [31:0] b, input logic [4:0] k, input logic d);
    logic [63:0] x;
    x = {b, b};
    if (d) begin
      x = x >> k;
      return x[31:0];
    end
    x = x << k;
    return x[63:32];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs are set just after a rising edge; handshakes are sampled mid-cycle.
  task automatic tick8();
    logic [7:0] e;
    #4;
    if (ov8 && or8) begin
      chk("out8_has_pending", 32'(q8.size() != 0), 32'd1);
      if (q8.size() != 0) begin
        e = q8.pop_front();
        chk("data8", {24'd0, rb8}, {24'd0, e});
      end
      lo8 = rb8;
      n_emit8++;
      emit8_cyc = cyc;
      $display("N8  out cyc=%0d data=%h", cyc, rb8);
    end
    if (iv8 && ir8) begin
      q8.push_back(ref8(b8, k8, d8));
      n_acc8++;
      acc8_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick32();
    logic [31:0] e;
    #4;
    if (ov32 && or32) begin
      chk("out32_has_pending", 32'(q32.size() != 0), 32'd1);
      if (q32.size() != 0) begin
        e = q32.pop_front();
        chk("data32", rb32, e);
      end
      if (n_emit32 == 0) begin
        first_emit32 = cyc;
        fo32 = rb32;
      end
      last_emit32 = cyc;
      n_emit32++;
      $display("N32 out cyc=%0d data=%h", cyc, rb32);
    end
    if (iv32 && ir32) begin
      q32.push_back(ref32(b32, k32, d32));
      if (n_acc32 == 0) first_acc32 = cyc;
      n_acc32++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send8(input logic [7:0] b, input logic [2:0] k, input logic d,
                       input logic [7:0] exp, input string tag);
    int a0, e0;
    a0 = n_acc8;
    e0 = n_emit8;
    b8 = b; k8 = k; d8 = d; iv8 = 1'b1; or8 = 1'b1;
    for (int i = 0; i < 10 && n_acc8 == a0; i++) tick8();
    iv8 = 1'b0;
    for (int i = 0; i < 20 && n_emit8 == e0; i++) tick8();
    chk({tag, "_emitted"}, 32'(n_emit8 - e0), 32'd1);
    chk(tag, {24'd0, lo8}, {24'd0, exp});
    chk({tag, "_latency"}, 32'(emit8_cyc - acc8_cyc), 32'd3);
  endtask

  initial begin
    logic [7:0] stall_val;
    int a0, e0;

    rst = 1'b1;
    iv8 = 0; or8 = 1; d8 = 0; b8 = 0; k8 = 0;
    iv32 = 0; or32 = 1; d32 = 0; b32 = 0; k32 = 0;
    lo8 = 0; fo32 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, ov8}, 32'd0);
    chk("rst_bits", {24'd0, rb8}, 32'd0);
    chk("rst_in_ready", {31'd0, ir8}, 32'd1);
    rst = 1'b0;
    tick8();
    chk("idle_in_ready", {31'd0, ir8}, 32'd1);

    // Directed single words with hand-computed results.
    send8(8'b1000_0000, 3'd3, 1'b0, 8'b0000_0100, "k3");
    send8(8'hA5,        3'd0, 1'b0, 8'hA5,        "k0_identity");
    send8(8'b1000_0001, 3'd7, 1'b0, 8'b1100_0000, "k7");
    send8(8'h01,        3'd5, 1'b0, 8'h20,        "k5");
`ifdef UNROT_DIR_EN
    send8(8'b0000_0100, 3'd3, 1'b1, 8'b1000_0000, "dir_right_k3");
    send8(8'h01,        3'd1, 1'b1, 8'h80,        "dir_right_k1");
    // Alternate direction per word in a back-to-back stream.
    e0 = n_emit8;
    or8 = 1'b1;
    iv8 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b8 = 8'h81 + 8'(i); k8 = 3'(i); d8 = i[0];
      tick8();
    end
    iv8 = 1'b0;
    for (int i = 0; i < 6; i++) tick8();
    chk("dir_alt_count", 32'(n_emit8 - e0), 32'd8);
    d8 = 1'b0;
`endif

    // Backpressure: consumer stalls while the producer keeps offering.
    a0 = n_acc8;
    e0 = n_emit8;
    or8 = 1'b0;
    iv8 = 1'b1;
    stall_val = 8'h00;
    for (int i = 0; i < 10; i++) begin
      b8 = 8'($urandom); k8 = 3'($urandom);
      if (i == 4) stall_val = rb8;
      tick8();
    end
    chk("bp_accepts", 32'(n_acc8 - a0), 32'd3);
    chk("bp_in_ready_low", {31'd0, ir8}, 32'd0);
    chk("bp_out_valid", {31'd0, ov8}, 32'd1);
    chk("bp_stable", {24'd0, rb8}, {24'd0, stall_val});
    iv8 = 1'b0;
    or8 = 1'b1;
    for (int i = 0; i < 8; i++) tick8();
    chk("bp_drained", 32'(n_emit8 - e0), 32'd3);
    chk("bp_queue_empty", 32'(q8.size()), 32'd0);

    // Reset with three words in flight: none may ever appear.
    or8 = 1'b0;
    iv8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b8 = 8'hF0 | 8'(i); k8 = 3'd2;
      tick8();
    end
    iv8 = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, ov8}, 32'd0);
    chk("midrst_bits", {24'd0, rb8}, 32'd0);
    chk("midrst_in_ready", {31'd0, ir8}, 32'd1);
    q8.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    e0 = n_emit8;
    or8 = 1'b1;
    for (int i = 0; i < 8; i++) tick8();
    chk("midrst_no_emit", 32'(n_emit8 - e0), 32'd0);

    // N=32 throughput: 100 back-to-back words, one out per cycle.
    or32 = 1'b1;
    iv32 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i == 0) begin
        b32 = 32'h0000_0001; k32 = 5'd4;
      end else begin
        b32 = $urandom; k32 = 5'($urandom);
      end
      tick32();
    end
    iv32 = 1'b0;
    for (int i = 0; i < 10; i++) tick32();
    chk("tp_count", 32'(n_emit32), 32'd100);
    chk("tp_first_latency", 32'(first_emit32 - first_acc32), 32'd5);
    chk("tp_contiguous", 32'(last_emit32 - first_emit32), 32'd99);
    chk("tp_first_word", fo32, 32'h0000_0010);

    // N=32 random handshakes on both sides.
    a0 = n_acc32;
    for (int i = 0; i < 6000 && (n_acc32 - a0) < 1000; i++) begin
      iv32 = 1'($urandom_range(0, 1));
      or32 = 1'($urandom_range(0, 3) != 0);
      b32 = $urandom; k32 = 5'($urandom);
      tick32();
    end
    iv32 = 1'b0;
    or32 = 1'b1;
    for (int i = 0; i < 10; i++) tick32();
    chk("rand_accepted", 32'(n_acc32 - a0), 32'd1000);
    chk("rand_queue_empty", 32'(q32.size()), 32'd0);
    chk("rand_total_out", 32'(n_emit32), 32'(n_acc32));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
